// File: rtl/knn_scheduler.sv
// knn_scheduler: time-shares one distance unit over L samples, keeps the K nearest and majority-votes their class
module knn_scheduler #(
    parameter int L  = 16,
    parameter int K  = 3,
    parameter int W  = 16,
    parameter int C  = 4,
    parameter int IW = $clog2(L),
    parameter int CW = $clog2(C)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   dist_req,
    output logic [IW-1:0]          dist_idx,
    input  logic                   dist_ack,
    input  logic [W-1:0]           dist_value,
    input  logic [W-1:0]           dist_type,
    output logic                   done,
    output logic [CW-1:0]          result_class,
    output logic [$clog2(K+1)-1:0] result_count,
    output logic [W-1:0]           nn_dist,
    output logic                   type_err
);
    localparam int KW = $clog2(K+1);
    typedef enum logic [2:0] {IDLE, ISSUE, INSERT, VOTE, DONE} state_t;
    state_t        state, state_n;
    logic [W-1:0]  cv, ct, sel_t;
    logic [W-1:0]  ld [K];
    logic [W-1:0]  ld_n [K];
    logic [W-1:0]  lt [K];
    logic [W-1:0]  lt_n [K];
    logic [K-1:0]  lv, lv_n, below;
    logic [KW-1:0] cnt [C];
    logic [KW-1:0] cnt_n [C];
    logic [KW-1:0] r, best;
    logic [CW-1:0] best_c;
    logic          sel_v;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? ISSUE : IDLE;
            ISSUE:   state_n = dist_ack ? INSERT : ISSUE;
            INSERT:  state_n = (dist_idx == IW'(L-1)) ? VOTE : ISSUE;
            VOTE:    state_n = (r == KW'(K-1)) ? DONE : VOTE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Moore outputs
    always_comb begin
        busy     = state != IDLE;
        dist_req = state == ISSUE;
        done     = state == DONE;
    end
    // stable sorted insert: the new entry lands after every entry whose distance is <= it
    always_comb begin
        for (int j = 0; j < K; j++) below[j] = cv < ld[j];
        ld_n[0] = below[0] ? cv : ld[0];
        lt_n[0] = below[0] ? ct : lt[0];
        lv_n[0] = below[0] | lv[0];
        for (int j = 1; j < K; j++) begin
            ld_n[j] = !below[j] ? ld[j] : below[j-1] ? ld[j-1] : cv;
            lt_n[j] = !below[j] ? lt[j] : below[j-1] ? lt[j-1] : ct;
            lv_n[j] = !below[j] ? lv[j] : below[j-1] ? lv[j-1] : 1'b1;
        end
    end
    // vote: add the current rank to its class counter and pick the lowest-index maximum
    always_comb begin
        sel_v  = 1'b0;
        sel_t  = '0;
        best   = '0;
        best_c = '0;
        for (int j = 0; j < K; j++) begin
            if (r == KW'(j)) begin
                sel_v = lv[j];
                sel_t = lt[j];
            end
        end
        for (int c = 0; c < C; c++) begin
            cnt_n[c] = cnt[c] + KW'(sel_v && sel_t == W'(c));
            if (cnt_n[c] > best) begin
                best   = cnt_n[c];
                best_c = CW'(c);
            end
        end
    end
    // datapath: sample index, capture, K list, vote counters and held results
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_idx     <= '0;
            cv           <= '0;
            ct           <= '0;
            lv           <= '0;
            r            <= '0;
            type_err     <= 1'b0;
            result_class <= '0;
            result_count <= '0;
            nn_dist      <= '0;
            for (int j = 0; j < K; j++) begin
                ld[j] <= '1;
                lt[j] <= '0;
            end
            for (int c = 0; c < C; c++) cnt[c] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dist_idx <= '0;
                    lv       <= '0;
                    r        <= '0;
                    type_err <= 1'b0;
                    for (int j = 0; j < K; j++) begin
                        ld[j] <= '1;
                        lt[j] <= '0;
                    end
                    for (int c = 0; c < C; c++) cnt[c] <= '0;
                end
                ISSUE: if (dist_ack) begin
                    cv <= dist_value;
                    ct <= dist_type;
                end
                INSERT: begin
                    ld       <= ld_n;
                    lt       <= lt_n;
                    lv       <= lv_n;
                    type_err <= type_err | (ct >= W'(C));
                    dist_idx <= dist_idx + 1'b1;
                end
                VOTE: begin
                    cnt <= cnt_n;
                    r   <= r + 1'b1;
                    if (r == KW'(K-1)) begin
                        result_class <= best_c;
                        result_count <= best;
                        nn_dist      <= ld[0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_knn_scheduler.sv
// tb_knn_scheduler: directed scenarios for the kNN sequencing controller with a delay-programmable distance unit
module tb_knn_scheduler;
    localparam int L = 4, K = 3, W = 16, C = 4, IW = 2, CW = 2, KW = 2;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, dist_ack = 1'b0;
    logic busy, dist_req, done, type_err;
    logic [IW-1:0] dist_idx;
    logic [W-1:0]  dist_value = '0, dist_type = '0, nn_dist;
    logic [CW-1:0] result_class;
    logic [KW-1:0] result_count;
    logic [W-1:0]  dv [L];
    logic [W-1:0]  dt [L];
    int checks = 0, failures = 0, ack_dly = 0, done_cnt = 0;
    int acks [$];

    knn_scheduler #(.L(L), .K(K), .W(W), .C(C)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .dist_req(dist_req), .dist_idx(dist_idx), .dist_ack(dist_ack),
        .dist_value(dist_value), .dist_type(dist_type), .done(done),
        .result_class(result_class), .result_count(result_count),
        .nn_dist(nn_dist), .type_err(type_err)
    );

    always #5 clk = ~clk;

    // distance unit model: answers after ack_dly waiting cycles and checks the request holds still
    initial begin : responder
        int wcnt;
        logic [IW-1:0] hold;
        wcnt = 0;
        hold = '0;
        forever begin
            @(posedge clk);
            #2;
            if (done === 1'b1) done_cnt++;
            if (dist_req === 1'b1) begin
                if (wcnt == 0) hold = dist_idx;
                else begin
                    checks++;
                    if (dist_idx !== hold) begin
                        failures++;
                        $display("FAIL req_idx_stable: got %0d want %0d", dist_idx, hold);
                    end
                end
                if (wcnt >= ack_dly) begin
                    dist_ack   = 1'b1;
                    dist_value = dv[dist_idx];
                    dist_type  = dt[dist_idx];
                    acks.push_back(int'(dist_idx));
                    wcnt = 0;
                end else begin
                    dist_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                dist_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one classification from IDLE; cycle 1 is the cycle after the edge that samples start
    task automatic run(input int dly, input bit start_in_done, output int dcyc, output logic b1,
                       output logic [CW-1:0] c1, output logic [CW-1:0] cls,
                       output logic [KW-1:0] cnt, output logic [W-1:0] nn, output logic terr);
        int n;
        ack_dly = dly;
        acks.delete();
        dcyc = -1;
        cls = '0;
        cnt = '0;
        nn = '0;
        terr = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        b1 = busy;
        c1 = result_class;
        while (done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (done === 1'b1) begin
            dcyc = n;
            cls = result_class;
            cnt = result_count;
            nn = nn_dist;
            terr = type_err;
        end
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks += 8;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0d want 0", busy); end
        if (dist_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0d want 0", dist_req); end
        if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0d want 0", done); end
        if (type_err !== 1'b0) begin failures++; $display("FAIL rst_type_err: got %0d want 0", type_err); end
        if (result_class !== 2'd0) begin failures++; $display("FAIL rst_class: got %0d want 0", result_class); end
        if (result_count !== 2'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", result_count); end
        if (nn_dist !== 16'd0) begin failures++; $display("FAIL rst_nn: got %0d want 0", nn_dist); end
        if (dist_idx !== 2'd0) begin failures++; $display("FAIL rst_idx: got %0d want 0", dist_idx); end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0d want 0", busy); end
    endtask

    task automatic test_basic();
        int dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        dv = '{16'd40, 16'd10, 16'd30, 16'd20};
        dt = '{16'd1, 16'd2, 16'd2, 16'd3};
        run(0, 1'b0, dc, b1, c1, cl, ct, nn, te);
        checks += 8;
        if (b1 !== 1'b1) begin failures++; $display("FAIL basic_busy1: got %0d want 1", b1); end
        if (dc != 12) begin failures++; $display("FAIL basic_done_cycle: got %0d want 12", dc); end
        if (cl !== 2'd2) begin failures++; $display("FAIL basic_class: got %0d want 2", cl); end
        if (ct !== 2'd2) begin failures++; $display("FAIL basic_count: got %0d want 2", ct); end
        if (nn !== 16'd10) begin failures++; $display("FAIL basic_nn: got %0d want 10", nn); end
        if (te !== 1'b0) begin failures++; $display("FAIL basic_type_err: got %0d want 0", te); end
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %0d want 0", done); end
        if (acks.size() != 4) begin failures++; $display("FAIL basic_ack_count: got %0d want 4", acks.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= acks.size() || acks[i] != i) begin
                failures++;
                $display("FAIL basic_ack_order[%0d]: got %0d want %0d", i, (i < acks.size()) ? acks[i] : -1, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        run(0, 1'b1, dc, b1, c1, cl, ct, nn, te);
        checks += 2;
        if (dc != 12) begin failures++; $display("FAIL b2b_done_cycle: got %0d want 12", dc); end
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done: got busy %0d want 0", busy); end
        step();
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_not_queued: got busy %0d want 0", busy); end
        if (result_class !== 2'd2) begin failures++; $display("FAIL b2b_held_class: got %0d want 2", result_class); end
        if (result_count !== 2'd2) begin failures++; $display("FAIL b2b_held_count: got %0d want 2", result_count); end
        if (nn_dist !== 16'd10) begin failures++; $display("FAIL b2b_held_nn: got %0d want 10", nn_dist); end
    endtask

    task automatic test_tie();
        int dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        dv = '{16'd5, 16'd6, 16'd7, 16'd8};
        dt = '{16'd3, 16'd1, 16'd0, 16'd2};
        run(0, 1'b0, dc, b1, c1, cl, ct, nn, te);
        checks += 5;
        if (c1 !== 2'd2) begin failures++; $display("FAIL tie_prev_held: got %0d want 2", c1); end
        if (dc != 12) begin failures++; $display("FAIL tie_done_cycle: got %0d want 12", dc); end
        if (cl !== 2'd0) begin failures++; $display("FAIL tie_class: got %0d want 0", cl); end
        if (ct !== 2'd1) begin failures++; $display("FAIL tie_count: got %0d want 1", ct); end
        if (nn !== 16'd5) begin failures++; $display("FAIL tie_nn: got %0d want 5", nn); end
    endtask

    task automatic test_equal();
        int dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        dv = '{16'd9, 16'd9, 16'd9, 16'd9};
        dt = '{16'd1, 16'd1, 16'd2, 16'd2};
        run(0, 1'b0, dc, b1, c1, cl, ct, nn, te);
        checks += 3;
        if (cl !== 2'd1) begin failures++; $display("FAIL equal_class: got %0d want 1", cl); end
        if (ct !== 2'd2) begin failures++; $display("FAIL equal_count: got %0d want 2", ct); end
        if (nn !== 16'd9) begin failures++; $display("FAIL equal_nn: got %0d want 9", nn); end
    endtask

    task automatic test_delay();
        int dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        dv = '{16'd40, 16'd10, 16'd30, 16'd20};
        dt = '{16'd1, 16'd2, 16'd2, 16'd3};
        run(3, 1'b0, dc, b1, c1, cl, ct, nn, te);
        checks += 5;
        if (dc != 24) begin failures++; $display("FAIL delay_done_cycle: got %0d want 24", dc); end
        if (cl !== 2'd2) begin failures++; $display("FAIL delay_class: got %0d want 2", cl); end
        if (ct !== 2'd2) begin failures++; $display("FAIL delay_count: got %0d want 2", ct); end
        if (nn !== 16'd10) begin failures++; $display("FAIL delay_nn: got %0d want 10", nn); end
        if (acks.size() != 4) begin failures++; $display("FAIL delay_ack_count: got %0d want 4", acks.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= acks.size() || acks[i] != i) begin
                failures++;
                $display("FAIL delay_ack_order[%0d]: got %0d want %0d", i, (i < acks.size()) ? acks[i] : -1, i);
            end
        end
    endtask

    task automatic test_type_err();
        int dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        dv = '{16'd40, 16'd10, 16'd30, 16'd20};
        dt = '{16'd1, 16'd7, 16'd2, 16'd3};
        run(0, 1'b0, dc, b1, c1, cl, ct, nn, te);
        checks += 4;
        if (te !== 1'b1) begin failures++; $display("FAIL terr_flag: got %0d want 1", te); end
        if (cl !== 2'd2) begin failures++; $display("FAIL terr_class: got %0d want 2", cl); end
        if (ct !== 2'd1) begin failures++; $display("FAIL terr_count: got %0d want 1", ct); end
        if (nn !== 16'd10) begin failures++; $display("FAIL terr_nn: got %0d want 10", nn); end
    endtask

    task automatic test_abort();
        int d0, dc;
        logic b1, te;
        logic [CW-1:0] c1, cl;
        logic [KW-1:0] ct;
        logic [W-1:0] nn;
        d0 = done_cnt;
        dv = '{16'd40, 16'd10, 16'd30, 16'd20};
        dt = '{16'd1, 16'd2, 16'd2, 16'd3};
        ack_dly = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        checks++;
        if (type_err !== 1'b0) begin failures++; $display("FAIL abort_terr_cleared: got %0d want 0", type_err); end
        step();
        start = 1'b0;
        checks++;
        if (dist_req !== 1'b1 || dist_idx !== 2'd1) begin
            failures++;
            $display("FAIL abort_second_issue: got req %0d idx %0d want req 1 idx 1", dist_req, dist_idx);
        end
        step();
        rst = 1'b1;
        step();
        checks += 6;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0d want 0", busy); end
        if (dist_req !== 1'b0) begin failures++; $display("FAIL abort_req: got %0d want 0", dist_req); end
        if (result_class !== 2'd0) begin failures++; $display("FAIL abort_class: got %0d want 0", result_class); end
        if (result_count !== 2'd0) begin failures++; $display("FAIL abort_count: got %0d want 0", result_count); end
        if (nn_dist !== 16'd0) begin failures++; $display("FAIL abort_nn: got %0d want 0", nn_dist); end
        if (dist_idx !== 2'd0) begin failures++; $display("FAIL abort_idx: got %0d want 0", dist_idx); end
        rst = 1'b0;
        repeat (5) step();
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_not_queued: got busy %0d want 0", busy); end
        if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - d0); end
        run(0, 1'b0, dc, b1, c1, cl, ct, nn, te);
        checks += 4;
        if (dc != 12) begin failures++; $display("FAIL fresh_done_cycle: got %0d want 12", dc); end
        if (cl !== 2'd2) begin failures++; $display("FAIL fresh_class: got %0d want 2", cl); end
        if (ct !== 2'd2) begin failures++; $display("FAIL fresh_count: got %0d want 2", ct); end
        if (nn !== 16'd10) begin failures++; $display("FAIL fresh_nn: got %0d want 10", nn); end
    endtask

    initial begin
        for (int i = 0; i < L; i++) begin
            dv[i] = '0;
            dt[i] = '0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_tie();
        test_equal();
        test_delay();
        test_type_err();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
